// File: rtl/text_pkg.sv
// Shared character constants, display strings and BCD converter types for the text overlay.
package text_pkg;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  localparam int PREFIX_LEN = 4;
  localparam int SCORE_LEN  = 8;
  localparam int BANNER_LEN = 22;

  localparam logic [7:0] PREFIX_STR [PREFIX_LEN] = '{"P", "T", "S", " "};

  localparam logic [7:0] BANNER_STR [BANNER_LEN] = '{
    "P", "R", "E", "S", "S", " ", "A", "N", "Y", " ", "K",
    "E", "Y", " ", "T", "O", " ", "S", "T", "A", "R", "T"
  };

  localparam logic [13:0] BCD_MAX = 14'd9999;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } bcd_state_t;

  // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] acc);
    logic [15:0] r;
    r = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) r[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter, saturating at 9999.
// Latency 16 cycles from start to done (LOAD 1, SHIFT 14, DONE 1); start while busy restarts.
module bin2bcd_seq
  import text_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  bcd_state_t  state, state_nxt;
  logic [13:0] sh;
  logic [15:0] acc;
  logic [3:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == 4'd13) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = LOAD;
  end

  // The operand is captured on the start edge itself, so the score only has to be valid with the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      sh  <= (bin > BCD_MAX) ? BCD_MAX : bin;
      acc <= '0;
      cnt <= '0;
    end else if (state == SHIFT) begin
      {acc, sh} <= {dabble_adjust(acc), sh} << 1;
      cnt       <= cnt + 4'd1;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign bcd  = acc;

endmodule

// File: rtl/text_overlay.sv
// Two-stage pixel pipeline mapping (hcount, vcount) to font ROM address and a registered text_on flag.
// Latency 2 cycles coordinate to text_on; free-running, no backpressure.
module text_overlay
  import text_pkg::*;
#(
  parameter int SCORE_X    = 16,
  parameter int SCORE_Y    = 8,
  parameter int BANNER_X   = 144,
  parameter int BANNER_Y   = 232,
  parameter int SCALE_LOG2 = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        frame_start,
  input  logic [13:0] score,
  input  logic        show_banner,
  output logic [7:0]  char_addr,
  output logic [2:0]  row_addr,
  input  logic [7:0]  bitmap,
  output logic        text_on,
  output logic        bcd_busy
);

  localparam int S = 1 << SCALE_LOG2;
  localparam int W = 8 * S;

  localparam logic [10:0] SX0 = 11'(SCORE_X);
  localparam logic [10:0] SX1 = 11'(SCORE_X + SCORE_LEN * W);
  localparam logic [10:0] SY0 = 11'(SCORE_Y);
  localparam logic [10:0] SY1 = 11'(SCORE_Y + W);
  localparam logic [10:0] BX0 = 11'(BANNER_X);
  localparam logic [10:0] BX1 = 11'(BANNER_X + BANNER_LEN * W);
  localparam logic [10:0] BY0 = 11'(BANNER_Y);
  localparam logic [10:0] BY1 = 11'(BANNER_Y + W);

  logic        bcd_done;
  logic [15:0] bcd_acc;
  logic [15:0] digits;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (frame_start),
    .bin   (score),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd_acc)
  );

  // Only a finished conversion reaches the screen, never a half-shifted accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        digits <= '0;
    else if (bcd_done) digits <= bcd_acc;
  end

  logic [10:0] h, v;
  logic        in_score, in_banner;

  assign h         = {1'b0, hcount};
  assign v         = {1'b0, vcount};
  assign in_score  = (h >= SX0) && (h < SX1) && (v >= SY0) && (v < SY1);
  assign in_banner = show_banner && (h >= BX0) && (h < BX1) && (v >= BY0) && (v < BY1);

  logic [9:0] dx, dy;
  logic [6:0] cidx;
  logic [3:0] nib;
  logic [7:0] ch_nxt;
  logic [2:0] row_nxt, bit_nxt;
  logic       hit_nxt;

  always_comb begin
    ch_nxt  = CH_SPACE;
    row_nxt = '0;
    bit_nxt = '0;
    hit_nxt = 1'b0;
    dx      = '0;
    dy      = '0;
    nib     = '0;
    if (in_score) begin
      hit_nxt = 1'b1;
      dx      = hcount - 10'(SCORE_X);
      dy      = vcount - 10'(SCORE_Y);
    end else if (in_banner) begin
      hit_nxt = 1'b1;
      dx      = hcount - 10'(BANNER_X);
      dy      = vcount - 10'(BANNER_Y);
    end
    cidx = 7'(dx >> (3 + SCALE_LOG2));
    if (in_score) begin
      case (cidx[1:0])
        2'd0:    nib = digits[15:12];
        2'd1:    nib = digits[11:8];
        2'd2:    nib = digits[7:4];
        default: nib = digits[3:0];
      endcase
      ch_nxt = cidx[2] ? (CH_ZERO + {4'h0, nib}) : PREFIX_STR[cidx[1:0]];
    end else if (in_banner) begin
      for (int i = 0; i < BANNER_LEN; i++) begin
        if (cidx == 7'(i)) ch_nxt = BANNER_STR[i];
      end
    end
    if (hit_nxt) begin
      row_nxt = 3'(dy >> SCALE_LOG2);
      bit_nxt = 3'(dx >> SCALE_LOG2);
    end
  end

  logic [2:0] bit_q;
  logic       hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_addr <= CH_SPACE;
      row_addr  <= '0;
      bit_q     <= '0;
      hit_q     <= 1'b0;
    end else begin
      char_addr <= ch_nxt;
      row_addr  <= row_nxt;
      bit_q     <= bit_nxt;
      hit_q     <= hit_nxt;
    end
  end

  // The font ROM answers combinationally, so bitmap lines up with stage-1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) text_on <= 1'b0;
    else        text_on <= hit_q & bitmap[3'd7 - bit_q];
  end

endmodule

// File: tb/tb_text_overlay.sv
// Directed bench for text_overlay with a behavioural font ROM and an in-order scoreboard.
module tb_text_overlay;

  localparam int FAR_H = 700;
  localparam int FAR_V = 400;

  logic        clk;
  logic        rst_n;
  logic [9:0]  hcount, vcount;
  logic        frame_start;
  logic [13:0] score;
  logic        show_banner;
  logic [7:0]  char_addr;
  logic [2:0]  row_addr;
  logic [7:0]  bitmap;
  logic        text_on;
  logic        bcd_busy;

  typedef struct {
    logic [7:0] ch;
    logic [2:0] row;
  } cexp_t;

  cexp_t ch_q[$];
  logic  on_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int sc          = 0;
  int pulse_at    = -1000;
  int disp        = 0;
  int next_disp   = 0;

  string BSTR = "PRESS ANY KEY TO START";
  string PSTR = "PTS ";

  text_overlay #(
    .SCORE_X(16), .SCORE_Y(8), .BANNER_X(144), .BANNER_Y(232), .SCALE_LOG2(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .frame_start (frame_start),
    .score       (score),
    .show_banner (show_banner),
    .char_addr   (char_addr),
    .row_addr    (row_addr),
    .bitmap      (bitmap),
    .text_on     (text_on),
    .bcd_busy    (bcd_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] font(input logic [7:0] c, input logic [2:0] r);
    return (c * 8'd37) ^ {r, r, r[1:0]} ^ 8'h5C;
  endfunction

  assign bitmap = font(char_addr, row_addr);

  function automatic void model(input int h, input int v, input logic sb, input int dsp,
                                output logic [7:0] ch, output logic [2:0] row, output logic on);
    int dx, dy, idx, p10;
    logic hit;
    logic [7:0] fnt;
    ch = 8'h20; row = 3'd0; on = 1'b0; hit = 1'b0; dx = 0; dy = 0;
    if (h >= 16 && h < 144 && v >= 8 && v < 24) begin
      dx = h - 16; dy = v - 8; idx = dx / 16; hit = 1'b1;
      if (idx < 4) ch = PSTR[idx];
      else begin
        p10 = (idx == 4) ? 1000 : (idx == 5) ? 100 : (idx == 6) ? 10 : 1;
        ch  = 8'h30 + 8'((dsp / p10) % 10);
      end
    end else if (sb && h >= 144 && h < 496 && v >= 232 && v < 248) begin
      dx = h - 144; dy = v - 232; idx = dx / 16; hit = 1'b1;
      ch = BSTR[idx];
    end
    if (hit) begin
      row = 3'((dy / 2) % 8);
      fnt = font(ch, row);
      on  = fnt[7 - ((dx / 2) % 8)];
    end
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at step %0d", tag, obs, exp, sc);
    end
  endtask

  // One pixel per cycle: check what matured, then present the next coordinate.
  task automatic step(input int h, input int v, input logic fs);
    logic [7:0] ch;
    logic [2:0] row;
    logic       on;
    cexp_t      c;
    @(negedge clk);
    sc++;
    chk("bcd_busy", 16'(bcd_busy), 16'((sc - pulse_at >= 1) && (sc - pulse_at <= 16)));
    if (ch_q.size() > 0) begin
      c = ch_q.pop_front();
      chk("char_addr", 16'(char_addr), 16'(c.ch));
      chk("row_addr", 16'(row_addr), 16'(c.row));
    end
    if (on_q.size() == 2) chk("text_on", 16'(text_on), 16'(on_q.pop_front()));
    if (sc - pulse_at >= 17) disp = next_disp;
    hcount      = 10'(h);
    vcount      = 10'(v);
    frame_start = fs;
    if (fs) begin
      pulse_at  = sc;
      next_disp = (score > 14'd9999) ? 9999 : int'(score);
    end
    model(h, v, show_banner, disp, ch, row, on);
    c.ch = ch; c.row = row;
    ch_q.push_back(c);
    on_q.push_back(on);
  endtask

  task automatic scan_row(input int v);
    for (int h = 12; h < 148; h++) step(h, v, 1'b0);
  endtask

  task automatic convert(input logic [13:0] val);
    score = val;
    step(FAR_H, FAR_V, 1'b1);
    repeat (20) step(FAR_H, FAR_V, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; hcount = '0; vcount = '0; frame_start = 1'b0; score = '0; show_banner = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_char_addr", 16'(char_addr), 16'h0020);
    chk("rst_row_addr", 16'(row_addr), 16'h0000);
    chk("rst_text_on", 16'(text_on), 16'h0000);
    chk("rst_bcd_busy", 16'(bcd_busy), 16'h0000);
    rst_n = 1'b1;

    for (int v = 6; v < 26; v++)
      for (int h = 12; h < 148; h++) step(h, v, 1'b0);

    convert(14'd1234);  scan_row(9);
    convert(14'd12000); scan_row(15);
    convert(14'd0);     scan_row(22);
    convert(14'd1234);

    score = 14'd7777;
    step(80, 12, 1'b1);
    for (int i = 1; i < 5; i++) step(80 + i, 12, 1'b0);
    score = 14'd42;
    step(85, 12, 1'b1);
    for (int h = 86; h < 146; h++) step(h, 12, 1'b0);
    repeat (4) step(FAR_H, FAR_V, 1'b0);
    scan_row(12);

    show_banner = 1'b1;
    for (int h = 140; h < 500; h++) step(h, 236, 1'b0);
    for (int h = 140; h < 500; h++) step(h, 247, 1'b0);
    show_banner = 1'b0;
    for (int h = 140; h < 500; h++) step(h, 236, 1'b0);

    score = 14'd5678;
    step(FAR_H, FAR_V, 1'b1);
    for (int i = 0; i < 6; i++) step(96 + i * 3, 10, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_bcd_busy", 16'(bcd_busy), 16'h0000);
    chk("async_text_on", 16'(text_on), 16'h0000);
    chk("async_char_addr", 16'(char_addr), 16'h0020);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ch_q.delete();
    on_q.delete();
    disp = 0; next_disp = 0; pulse_at = -1000;
    scan_row(8);
    scan_row(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
